ula_execucao: RTL and testbench

Execute/writeback stage of the Nano 8-bit datapath. It sits directly downstream of the register bank: it takes the two registered operands read from the bank plus a decoded opcode and a destination address, and computes an 8-bit result. It returns that result to the bank's write port as a single-cycle write pulse. Most operations complete in one cycle; multiply is a sequential shift-add that stalls issue through a ready handshake.

---
 rtl/nano_pkg.sv | 27 ++
 rtl/multiplicador_seq.sv | 61 ++++++
 rtl/ula_execucao.sv | 155 +++++++++++++++
 tb/tb_ula_execucao.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
`default_nettype none
// ============================================================================
// Module : nano_pkg
// Brief  : Opcodes, execute-stage FSM encoding and datapath defaults for Nano
// Rev    : 1.0
// ============================================================================
package nano_pkg;

  localparam int LARG_PADRAO   = 8;
  localparam int NREG_W_PADRAO = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    MULT   = 1'b1
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/multiplicador_seq.sv
`default_nettype none
// ============================================================================
// Module : multiplicador_seq
// Brief  : Unsigned shift-add multiplier, one partial product per cycle
// Rev    : 1.0
// ============================================================================
module multiplicador_seq
  import nano_pkg::*;
#(
  parameter int LARG       = LARG_PADRAO,
  parameter int MUL_CICLOS = LARG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ativo,
  input  logic [LARG-1:0]   multiplicando,
  input  logic [LARG-1:0]   multiplicador,
  output logic              done,
  output logic [2*LARG-1:0] produto
);

  localparam int            CW       = $clog2(MUL_CICLOS + 1);
  localparam logic [CW-1:0] C_ULTIMO = CW'(MUL_CICLOS - 1);

  logic [2*LARG-1:0] r_mcand;
  logic [LARG-1:0]   r_mplier;
  logic [2*LARG-1:0] r_acc;
  logic [CW-1:0]     r_cont;
  logic [2*LARG-1:0] w_parcial;
  logic [2*LARG-1:0] w_acc_prox;

  assign w_parcial  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_prox = r_acc + w_parcial;

  // The final iteration's sum is presented directly so the owner can register
  // it on the same edge that would otherwise store it here.
  assign done    = ativo && (r_cont == C_ULTIMO);
  assign produto = w_acc_prox;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cont   <= '0;
    end else if (start) begin
      r_mcand  <= {{LARG{1'b0}}, multiplicando};
      r_mplier <= multiplicador;
      r_acc    <= '0;
      r_cont   <= '0;
    end else if (ativo) begin
      r_acc    <= w_acc_prox;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cont   <= r_cont + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ula_execucao.sv
`default_nettype none
// ============================================================================
// Module : ula_execucao
// Brief  : Nano execute/writeback stage: ALU, sequential multiply, flags
// Rev    : 1.0
// ============================================================================
module ula_execucao
  import nano_pkg::*;
#(
  parameter int LARG       = LARG_PADRAO,
  parameter int NREG_W     = NREG_W_PADRAO,
  parameter int MUL_CICLOS = LARG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validIn,
  input  logic [2:0]        op,
  input  logic [NREG_W-1:0] addDest,
  input  logic [LARG-1:0]   dadoA,
  input  logic [LARG-1:0]   dadoB,
  output logic              ready,
  output logic              wrEn,
  output logic [NREG_W-1:0] addWr,
  output logic [LARG-1:0]   dadoWr,
  output logic              flagZ,
  output logic              flagC
);

  estado_t           r_estado;
  estado_t           w_prox_estado;
  logic              w_emite;
  logic              w_inicia_mul;
  logic              w_grava_ula;
  logic              w_mul_fim;
  logic [2*LARG-1:0] w_produto;
  logic [LARG-1:0]   w_res;
  logic              w_carry;

  logic [NREG_W-1:0] r_dest;
  logic              r_wr;
  logic [NREG_W-1:0] r_addr;
  logic [LARG-1:0]   r_dado;
  logic              r_z;
  logic              r_c;

  assign ready   = (r_estado == OCIOSO);
  assign w_emite = validIn && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_inicia_mul  = 1'b0;
    w_grava_ula   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_emite) begin
          if (op == OP_MUL) begin
            w_inicia_mul  = 1'b1;
            w_prox_estado = MULT;
          end else begin
            w_grava_ula = 1'b1;
          end
        end
      end
      MULT: begin
        if (w_mul_fim) begin
          w_prox_estado = OCIOSO;
        end
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  // Bit LARG of the widened add/sub is carry out or borrow respectively.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (op)
      OP_ADD: {w_carry, w_res} = {1'b0, dadoA} + {1'b0, dadoB};
      OP_SUB: {w_carry, w_res} = {1'b0, dadoA} - {1'b0, dadoB};
      OP_AND: w_res = dadoA & dadoB;
      OP_OR:  w_res = dadoA | dadoB;
      OP_XOR: w_res = dadoA ^ dadoB;
      OP_SHL: {w_carry, w_res} = {dadoA, 1'b0};
      OP_SHR: {w_res, w_carry} = {1'b0, dadoA};
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  multiplicador_seq #(
    .LARG       (LARG),
    .MUL_CICLOS (MUL_CICLOS)
  ) u_mul (
    .clk           (clk),
    .rst           (rst),
    .start         (w_inicia_mul),
    .ativo         (r_estado == MULT),
    .multiplicando (dadoA),
    .multiplicador (dadoB),
    .done          (w_mul_fim),
    .produto       (w_produto)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dest <= '0;
    end else if (w_inicia_mul) begin
      r_dest <= addDest;
    end
  end

  // Address, data and flags only move together with a write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_dado <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (w_grava_ula) begin
        r_wr   <= 1'b1;
        r_addr <= addDest;
        r_dado <= w_res;
        r_z    <= (w_res == '0);
        r_c    <= w_carry;
      end else if (w_mul_fim) begin
        r_wr   <= 1'b1;
        r_addr <= r_dest;
        r_dado <= w_produto[LARG-1:0];
        r_z    <= (w_produto[LARG-1:0] == '0);
        r_c    <= |w_produto[2*LARG-1:LARG];
      end
    end
  end

  assign wrEn   = r_wr;
  assign addWr  = r_addr;
  assign dadoWr = r_dado;
  assign flagZ  = r_z;
  assign flagC  = r_c;

endmodule
`default_nettype wire

// File: tb/tb_ula_execucao.sv
`default_nettype none
// ============================================================================
// Module : tb_ula_execucao
// Brief  : Directed self-checking bench for ula_execucao with reference model
// Rev    : 1.0
// ============================================================================
module tb_ula_execucao;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       validIn = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] addDest = 3'd0;
  logic [7:0] dadoA = 8'd0;
  logic [7:0] dadoB = 8'd0;
  logic       ready;
  logic       wrEn;
  logic [2:0] addWr;
  logic [7:0] dadoWr;
  logic       flagZ;
  logic       flagC;

  int checks = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  ula_execucao dut (
    .clk     (clk),
    .rst     (rst_n),
    .validIn (validIn),
    .op      (op),
    .addDest (addDest),
    .dadoA   (dadoA),
    .dadoB   (dadoB),
    .ready   (ready),
    .wrEn    (wrEn),
    .addWr   (addWr),
    .dadoWr  (dadoWr),
    .flagZ   (flagZ),
    .flagC   (flagC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result and carry from plain integer arithmetic.
  function automatic logic [8:0] alu_model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    logic cy;
    ia = a;
    ib = b;
    r  = 0;
    cy = 1'b0;
    case (o)
      3'd0: begin r = ia + ib; cy = (r > 255); end
      3'd1: begin r = ia - ib + 256; cy = (ia < ib); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = ia * 2; cy = (ia >= 128); end
      3'd6: begin r = ia / 2; cy = (ia % 2 == 1); end
      default: r = 0;
    endcase
    return {cy, r[7:0]};
  endfunction

  int         m_busy = 0;
  logic       m_wr = 1'b0;
  logic [2:0] m_addr = 3'd0;
  logic [7:0] m_data = 8'd0;
  logic       m_z = 1'b0;
  logic       m_c = 1'b0;
  logic [2:0] m_pend_addr = 3'd0;
  int         m_pend_prod = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [8:0] rr;
    if (!rst_n) begin
      m_busy <= 0;
      m_wr   <= 1'b0;
      m_addr <= 3'd0;
      m_data <= 8'd0;
      m_z    <= 1'b0;
      m_c    <= 1'b0;
    end else begin
      m_wr <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_wr   <= 1'b1;
          m_addr <= m_pend_addr;
          m_data <= 8'(m_pend_prod % 256);
          m_z    <= (m_pend_prod % 256 == 0);
          m_c    <= (m_pend_prod / 256 != 0);
        end
      end else if (validIn) begin
        if (op == 3'd7) begin
          m_busy      <= 8;
          m_pend_addr <= addDest;
          m_pend_prod <= int'(dadoA) * int'(dadoB);
        end else begin
          rr = alu_model(op, dadoA, dadoB);
          m_wr   <= 1'b1;
          m_addr <= addDest;
          m_data <= rr[7:0];
          m_z    <= (rr[7:0] == 8'd0);
          m_c    <= rr[8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_ready", ready, (m_busy == 0));
      chk("cmp_wrEn", wrEn, m_wr);
      chk("cmp_addWr", addWr, m_addr);
      chk("cmp_dadoWr", dadoWr, m_data);
      chk("cmp_flagZ", flagZ, m_z);
      chk("cmp_flagC", flagC, m_c);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    validIn = 1'b1;
    op      = o;
    dadoA   = a;
    dadoB   = b;
    addDest = d;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string nm, input logic [2:0] ad, input logic [7:0] dt, input logic z, input logic c);
    chk({nm, "_wrEn"}, wrEn, 1'b1);
    chk({nm, "_addWr"}, addWr, ad);
    chk({nm, "_dadoWr"}, dadoWr, dt);
    chk({nm, "_flagZ"}, flagZ, z);
    chk({nm, "_flagC"}, flagC, c);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_wrEn", wrEn, 1'b0);
    chk("rst_addWr", addWr, 3'd0);
    chk("rst_dadoWr", dadoWr, 8'd0);
    chk("rst_flags", {flagZ, flagC}, 2'b00);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    issue(3'd0, 8'd3, 8'd4, 3'd2);
    chk_wr("add_3_4", 3'd2, 8'd7, 1'b0, 1'b0);
    issue(3'd0, 8'hFF, 8'h01, 3'd1);
    chk_wr("add_ff_01", 3'd1, 8'h00, 1'b1, 1'b1);
    issue(3'd1, 8'h05, 8'h06, 3'd3);
    chk_wr("sub_5_6", 3'd3, 8'hFF, 1'b0, 1'b1);
    validIn = 1'b0;
    @(negedge clk);
    chk("hold_wrEn", wrEn, 1'b0);
    chk("hold_dadoWr", dadoWr, 8'hFF);

    issue(3'd4, 8'hAA, 8'hAA, 3'd4);
    chk_wr("b2b_xor", 3'd4, 8'h00, 1'b1, 1'b0);
    issue(3'd5, 8'h81, 8'h00, 3'd5);
    chk_wr("b2b_shl", 3'd5, 8'h02, 1'b0, 1'b1);
    issue(3'd6, 8'h01, 8'h00, 3'd6);
    chk_wr("b2b_shr", 3'd6, 8'h00, 1'b1, 1'b1);
    issue(3'd2, 8'hF0, 8'h3C, 3'd0);
    chk_wr("and_r0", 3'd0, 8'h30, 1'b0, 1'b0);
    issue(3'd3, 8'h0F, 8'h30, 3'd7);
    chk_wr("or", 3'd7, 8'h3F, 1'b0, 1'b0);

    // Multiply with an ADD held on the input throughout the stall.
    issue(3'd7, 8'h0C, 8'h0A, 3'd5);
    op = 3'd0; dadoA = 8'd1; dadoB = 8'd1; addDest = 3'd1;
    chk("mul_stall_ready", ready, 1'b0);
    chk("mul_stall_wrEn", wrEn, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("mul_stall_ready", ready, 1'b0);
      chk("mul_stall_wrEn", wrEn, 1'b0);
    end
    @(negedge clk);
    chk_wr("mul_0c_0a", 3'd5, 8'h78, 1'b0, 1'b0);
    chk("mul_done_ready", ready, 1'b1);
    @(negedge clk);
    validIn = 1'b0;
    chk_wr("held_add", 3'd1, 8'd2, 1'b0, 1'b0);

    issue(3'd7, 8'h20, 8'h10, 3'd3);
    validIn = 1'b0;
    repeat (7) @(negedge clk);
    chk("mul_ovf_pre_wrEn", wrEn, 1'b0);
    @(negedge clk);
    chk_wr("mul_20_10", 3'd3, 8'h00, 1'b1, 1'b1);

    issue(3'd7, 8'hFF, 8'hFF, 3'd6);
    validIn = 1'b0;
    repeat (8) @(negedge clk);
    chk_wr("mul_ff_ff", 3'd6, 8'h01, 1'b0, 1'b1);

    // Reset in the 4th MULT cycle aborts the multiply.
    issue(3'd7, 8'd3, 8'd3, 3'd4);
    validIn = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_wrEn", wrEn, 1'b0);
    chk("abort_addWr", addWr, 3'd0);
    chk("abort_dadoWr", dadoWr, 8'd0);
    chk("abort_flags", {flagZ, flagC}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_wr", wrEn, 1'b0);
    end

    issue(3'd1, 8'h09, 8'h09, 3'd2);
    chk_wr("post_abort_sub", 3'd2, 8'h00, 1'b1, 1'b0);
    validIn = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
